// File: rtl/regwr_if.sv
// Port bundle between the register-file write arbiter and its two requesters.
// The slave side is the arbiter. The master side is the pipeline, the multi-cycle unit and the bench.
interface regwr_if;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        regwrite;
    logic [4:0]  regtowrite;
    logic [31:0] datatowrite;
    logic        buf_valid;
    logic [4:0]  buf_reg;
    logic [31:0] buf_data;
    logic        stall_req;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output b_ready, regwrite, regtowrite, datatowrite,
               buf_valid, buf_reg, buf_data, stall_req
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  b_ready, regwrite, regtowrite, datatowrite,
               buf_valid, buf_reg, buf_data, stall_req
    );
endinterface

// File: rtl/regwr_arb.sv
// Shares the register file's single write port between pipeline writeback (A, always wins)
// and a multi-cycle result source (B, one-entry holding buffer with starvation stall request).
module regwr_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    regwr_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        regwrite_reg, regwrite_next;
    logic [4:0]  regtowrite_reg, regtowrite_next;
    logic [31:0] datatowrite_reg, datatowrite_next;
    logic        buf_valid_reg, buf_valid_next;
    logic [4:0]  buf_dst_reg, buf_dst_next;
    logic [31:0] buf_data_reg, buf_data_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        stall_reg, stall_next;

    logic a_eff, drain, kill, accept, load;

    always_comb begin
        a_eff  = bus.a_valid & (bus.a_reg != 5'd0);
        drain  = buf_valid_reg & ~a_eff;
        // A younger A write to the same register makes the buffered B result dead.
        kill   = buf_valid_reg & a_eff & (bus.a_reg == buf_dst_reg);
        accept = bus.b_valid & (~buf_valid_reg | drain);
        load   = accept & (bus.b_reg != 5'd0);
    end

    always_comb begin
        regwrite_next    = 1'b0;
        regtowrite_next  = regtowrite_reg;
        datatowrite_next = datatowrite_reg;
        buf_valid_next   = buf_valid_reg;
        buf_dst_next     = buf_dst_reg;
        buf_data_next    = buf_data_reg;
        starve_cnt_next  = starve_cnt_reg;

        if (a_eff) begin
            regwrite_next    = 1'b1;
            regtowrite_next  = bus.a_reg;
            datatowrite_next = bus.a_data;
        end else if (buf_valid_reg) begin
            regwrite_next    = 1'b1;
            regtowrite_next  = buf_dst_reg;
            datatowrite_next = buf_data_reg;
        end

        if (load) begin
            buf_valid_next = 1'b1;
            buf_dst_next   = bus.b_reg;
            buf_data_next  = bus.b_data;
        end else if (drain | kill) begin
            buf_valid_next = 1'b0;
        end

        if (drain | kill) begin
            starve_cnt_next = 4'd0;
        end else if (buf_valid_reg & a_eff & (starve_cnt_reg < LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end

        // Stall holds until the buffer actually empties, even across a drain-and-refill.
        stall_next = buf_valid_next & (stall_reg | (starve_cnt_next == LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_reg    <= 1'b0;
            regtowrite_reg  <= 5'd0;
            datatowrite_reg <= 32'd0;
            buf_valid_reg   <= 1'b0;
            buf_dst_reg     <= 5'd0;
            buf_data_reg    <= 32'd0;
            starve_cnt_reg  <= 4'd0;
            stall_reg       <= 1'b0;
        end else begin
            regwrite_reg    <= regwrite_next;
            regtowrite_reg  <= regtowrite_next;
            datatowrite_reg <= datatowrite_next;
            buf_valid_reg   <= buf_valid_next;
            buf_dst_reg     <= buf_dst_next;
            buf_data_reg    <= buf_data_next;
            starve_cnt_reg  <= starve_cnt_next;
            stall_reg       <= stall_next;
        end
    end

    assign bus.b_ready     = ~buf_valid_reg | drain;
    assign bus.regwrite    = regwrite_reg;
    assign bus.regtowrite  = regtowrite_reg;
    assign bus.datatowrite = datatowrite_reg;
    assign bus.buf_valid   = buf_valid_reg;
    assign bus.buf_reg     = buf_dst_reg;
    assign bus.buf_data    = buf_data_reg;
    assign bus.stall_req   = stall_reg;
endmodule

// File: tb/tb_regwr_arb.sv
// Self-checking bench for regwr_arb: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model and register-file image.
module tb_regwr_arb;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regwr_if bus ();

    regwr_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the holding buffer is a queue of {reg, data} entries (at most one).
    logic [36:0] mq[$];
    int          m_starve = 0;
    logic        m_stall = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_rf[32];
    logic [31:0] d_rf[32];

    // Values sampled by the last cycle() call.
    logic        s_ready, s_we, s_bv, s_st;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        bufv;
        logic        st;
    } vec_t;
    vec_t tbl[16];

    always @(negedge clk) begin
        if (bus.regwrite) d_rf[bus.regtowrite] <= bus.datatowrite;
        if (m_we)         m_rf[m_addr] <= m_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_addr   = 5'd0;
        m_data   = 32'd0;
    endtask

    task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bit aeff;
        bit ready;
        logic [36:0] e;
        aeff  = av && (ar != 5'd0);
        ready = (mq.size() == 0) || !aeff;
        m_we  = 1'b0;
        if (aeff) begin
            m_we = 1'b1; m_addr = ar; m_data = ad;
            if (mq.size() != 0) begin
                if (mq[0][36:32] == ar) begin
                    void'(mq.pop_front());
                    m_starve = 0;
                end else if (m_starve < LIMIT) begin
                    m_starve++;
                end
            end
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
            m_starve = 0;
        end
        if (bv && ready && (br != 5'd0)) mq.push_back({br, bd});
        if (mq.size() == 0)         m_stall = 1'b0;
        else if (m_starve == LIMIT) m_stall = 1'b1;
    endtask

    // One clock cycle: drive inputs, check b_ready before the edge, step the model, check after.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bit m_ready;
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        #1;
        m_ready = (mq.size() == 0) || !(av && (ar != 5'd0));
        s_ready = bus.b_ready;
        chk("model_b_ready", bus.b_ready, m_ready);
        @(posedge clk);
        model_step(av, ar, ad, bv, br, bd);
        #1;
        s_we = bus.regwrite; s_addr = bus.regtowrite; s_data = bus.datatowrite;
        s_bv = bus.buf_valid; s_st = bus.stall_req;
        chk("model_regwrite", bus.regwrite, m_we);
        chk("model_regtowrite", bus.regtowrite, m_addr);
        chk("model_datatowrite", bus.datatowrite, m_data);
        chk("model_buf_valid", bus.buf_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("model_buf_reg", bus.buf_reg, mq[0][36:32]);
            chk("model_buf_data", bus.buf_data, mq[0][31:0]);
        end
        chk("model_stall_req", bus.stall_req, m_stall);
        $display("[TB] a=%0b r%0d %h b=%0b r%0d %h rdy=%0b -> we=%0b r%0d %h bv=%0b st=%0b",
                 av, ar, ad, bv, br, bd, s_ready, s_we, s_addr, s_data, s_bv, s_st);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_regwrite"}, bus.regwrite, 1'b0);
        chk({tag, "_regtowrite"}, bus.regtowrite, 5'd0);
        chk({tag, "_datatowrite"}, bus.datatowrite, 32'd0);
        chk({tag, "_buf_valid"}, bus.buf_valid, 1'b0);
        chk({tag, "_buf_reg"}, bus.buf_reg, 5'd0);
        chk({tag, "_buf_data"}, bus.buf_data, 32'd0);
        chk({tag, "_stall_req"}, bus.stall_req, 1'b0);
        chk({tag, "_b_ready"}, bus.b_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'd0;
            d_rf[i] = 32'd0;
        end
        bus.a_valid = 1'b0; bus.a_reg = 5'd0; bus.a_data = 32'd0;
        bus.b_valid = 1'b0; bus.b_reg = 5'd0; bus.b_data = 32'd0;

        // {av, ar, ad, bv, br, bd, ready, we, waddr, wdata, buf_valid, stall}
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  32'h30, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  32'h40, 1'b1, 1'b1, 5'd3, 32'h30,       1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6,  32'h60, 1'b1, 1'b1, 5'd4, 32'h40,       1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd6, 32'h60,       1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd6, 32'h60,       1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  32'h11, 1'b1, 1'b0, 5'd6, 32'h60,       1'b1, 1'b0};
        tbl[8]  = '{1'b1, 5'd9, 32'h900,      1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd9, 32'h900,      1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'd9, 32'h901,      1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd9, 32'h901,      1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd7, 32'h11,       1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'h55, 1'b1, 1'b0, 5'd7, 32'h11,       1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h22, 1'b1, 1'b0, 5'd7, 32'h11,       1'b1, 1'b0};
        tbl[13] = '{1'b1, 5'd8, 32'h33,       1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 5'd8, 32'h33,       1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd8, 32'h33,       1'b0, 1'b0};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd8, 32'h33,       1'b0, 1'b0};

        // Power-on reset
        #12;
        chk_all_reset("por");
        #10;
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
            chk($sformatf("vec%0d_b_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_regwrite", i), s_we, tbl[i].we);
            chk($sformatf("vec%0d_regtowrite", i), s_addr, tbl[i].wa);
            chk($sformatf("vec%0d_datatowrite", i), s_data, tbl[i].wd);
            chk($sformatf("vec%0d_buf_valid", i), s_bv, tbl[i].bufv);
            chk($sformatf("vec%0d_stall_req", i), s_st, tbl[i].st);
        end
        chk("waw_r8_final", d_rf[8], 32'h33);

        // Starvation: buffer full, A writes distinct registers back to back
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 5'(k), 32'(k), 1'b0, 5'd0, 32'd0);
            chk($sformatf("starve%0d_b_ready", k), s_ready, 1'b0);
            chk($sformatf("starve%0d_buf_valid", k), s_bv, 1'b1);
            chk($sformatf("starve%0d_stall_req", k), s_st, k >= LIMIT);
        end
        idle();
        chk("starve_drain_regwrite", s_we, 1'b1);
        chk("starve_drain_regtowrite", s_addr, 5'd12);
        chk("starve_drain_data", s_data, 32'hC0);
        chk("starve_drain_buf_valid", s_bv, 1'b0);
        chk("starve_drain_stall_req", s_st, 1'b0);

        // Reset mid-operation with a full buffer and stall_req raised
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020);
        for (int k = 1; k <= 5; k++) cycle(1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, 5'd0, 32'd0);
        chk("pre_reset_stall_req", s_st, 1'b1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_reset("midop");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("post_reset%0d_regwrite", k), s_we, 1'b0);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end
        for (int k = 0; k < 3; k++) idle();

        @(negedge clk);
        #1;
        for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), d_rf[r], m_rf[r]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
